// File: rtl/serial_comparator.sv
// Bit-serial a-b comparator: one bit per clock, LSB first, producing z/n/v flags and the difference.
// Optional SERIAL_COMPARATOR_ABORT_EN adds an abort input that cancels a compare in progress.
module serial_comparator_bit (
  input  logic a_bit,
  input  logic b_bit,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic nb;
  assign nb   = ~b_bit;
  assign s    = a_bit ^ nb ^ cin;
  assign cout = (a_bit & nb) | (a_bit & cin) | (nb & cin);
endmodule

module serial_comparator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_COMPARATOR_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic [WIDTH-1:0] diff
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_nx;
  logic             mode_sh, carry, nz;
  logic [CNT_W-1:0] idx;
  logic             s_bit, c_bit, last, abort_hit, ovf;

`ifdef SERIAL_COMPARATOR_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Shadow operands shift right so the current bit is always at index 0.
  serial_comparator_bit u_bit (
    .a_bit(a_sh[0]),
    .b_bit(b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign last    = (idx == CNT_W'(WIDTH-1));
  assign diff_nx = {s_bit, diff_sh[WIDTH-1:1]};
  // carry still holds the carry into the MSB while the last bit is processed.
  assign ovf     = carry ^ c_bit;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (abort_hit || last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      z       <= 1'b0;
      n       <= 1'b0;
      v       <= 1'b0;
      diff    <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      mode_sh <= 1'b0;
      carry   <= 1'b0;
      nz      <= 1'b0;
      idx     <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            mode_sh <= signed_mode;
            idx     <= '0;
            carry   <= 1'b1;
            nz      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (abort_hit) begin
            busy <= 1'b0;
          end else begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= diff_nx;
            carry   <= c_bit;
            nz      <= nz | s_bit;
            if (!last) idx <= idx + CNT_W'(1);
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
              diff <= diff_nx;
              z    <= ~(nz | s_bit);
              if (mode_sh) begin
                v <= ovf;
                n <= s_bit ^ ovf;
              end else begin
                v <= 1'b0;
                n <= ~c_bit;
              end
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=4): directed cases from the test plan plus random compares.
module tb_serial_comparator;
  localparam int W = 4;

  typedef struct {
    logic         z, n, v;
    logic [W-1:0] diff;
    int           cyc;
  } exp_t;

  logic clk = 0, rst = 1, start = 0, signed_mode = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, z, n, v;
  logic [W-1:0] diff;
`ifdef SERIAL_COMPARATOR_ABORT_EN
  logic abort = 0;
`endif

  int   n_tests = 0, n_fail = 0, cyc = 0;
  exp_t exp_q[$];
  logic rst_q = 1;

  serial_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
`ifdef SERIAL_COMPARATOR_ABORT_EN
    .abort(abort),
`endif
    .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .z(z), .n(n), .v(v), .diff(diff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic m);
    exp_t e;
    int ua, ub, sa, sb, d;
    ua = int'(ai); ub = int'(bi);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    e.diff = W'(ua - ub);
    e.z = (ua == ub);
    if (m) begin
      d   = sa - sb;
      e.n = (sa < sb);
      e.v = (d > 2**(W-1) - 1) || (d < -(2**(W-1)));
    end else begin
      e.n = (ua < ub);
      e.v = 1'b0;
    end
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done, and checks outputs hold between completions.
  logic [W+2:0] held = '0;
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("result", int'({z, n, v, diff}), int'({e.z, e.n, e.v, e.diff}));
      end
    end else if (!rst_q) begin
      check("hold", int'({z, n, v, diff}), int'(held));
    end
    held = {z, n, v, diff};
  end

  // Drives start now; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic m);
    exp_t e;
    start = 1; a = ai; b = bi; signed_mode = m;
    @(posedge clk); #1;
    start = 0;
    e = model(ai, bi, m);
    e.cyc = cyc + W;
    exp_q.push_back(e);
    check("busy_after_start", int'(busy), 1);
  endtask

  // Returns at the negedge of the done cycle, or flags a timeout.
  task automatic wait_done();
    for (int k = 0; k < W + 6; k++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_one(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic m);
    issue(ai, bi, m);
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'({busy, done, z, n, v, diff}), 0);
    rst = 0;
    @(posedge clk); #1;

    run_one(4'b0101, 4'b0011, 1);
    run_one(4'b0101, 4'b0101, 1);
    run_one(4'b0101, 4'b0110, 1);
    run_one(4'b0000, 4'b0001, 1);
    run_one(4'b0111, 4'b1000, 1);
    run_one(4'b0111, 4'b1000, 0);
    run_one(4'b1111, 4'b0000, 0);
    run_one(4'b1000, 4'b0111, 1);

    // Extra start and operand changes during RUN are ignored; then start in the done cycle.
    issue(4'b0110, 4'b0010, 1);
    for (int k = 0; k < W - 1; k++) begin
      start = 1; a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 0;
    @(posedge clk); #1;
    check("done_in_cycle", int'(done), 1);
    issue(4'b0011, 4'b0110, 0);
    wait_done();
    @(posedge clk); #1;

    // Reset at bit index 2 aborts; no done may follow.
    issue(4'b0001, 4'b0111, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    check("rst_mid_run", int'({busy, done, z, n, v, diff}), 0);
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1; rst = 1; a = 4'b0010; b = 4'b0001;
    @(posedge clk); #1;
    start = 0; rst = 0;
    @(posedge clk); #1;
    check("start_with_rst", int'(busy), 0);

`ifdef SERIAL_COMPARATOR_ABORT_EN
    run_one(4'b0101, 4'b0101, 1);
    issue(4'b0001, 4'b0010, 1);
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_keeps_z", int'(z), 1);
    repeat (W + 2) @(posedge clk);
    #1;
`endif

    for (int t = 0; t < 150; t++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      issue(ra, rb, 1'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (W + 2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
